// File: rtl/branch_issue_queue.sv
// ---------------------------------------------------------------------------
// branch_issue_queue
//   In-order issue queue for branch micro-ops. Entries wait until their
//   source operand and condition flags are available, either at dispatch or
//   later through writeback-bus snooping. The head entry then moves into a
//   registered output stage that drives the execute-branch port. Issue
//   handshake: VALID/payload out, LOCK back.
//
// Ports
//   iCLOCK, iRESET_SYNC      clock, synchronous active-high reset
//   iFREE_RESTART            pipeline flush, same effect as reset
//   iDISPATCH_*              dispatch request and branch micro-op fields
//   oDISPATCH_FULL           queue full; a dispatch presented now is dropped
//   iWB_*                    writeback bus snooped for operand/flag wakeup
//   oEX_BRANCH_*             registered issue stage to the branch execute port
//   iEX_BRANCH_LOCK          execute port busy; the output stage holds
//   oCOUNT                   queued entries, not counting the output stage
// ---------------------------------------------------------------------------
module branch_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             iCLOCK,
  input  logic             iRESET_SYNC,
  input  logic             iFREE_RESTART,
  input  logic             iDISPATCH_VALID,
  input  logic [5:0]       iDISPATCH_COMMIT_TAG,
  input  logic [4:0]       iDISPATCH_CMD,
  input  logic [3:0]       iDISPATCH_CC,
  input  logic [31:0]      iDISPATCH_PC,
  input  logic             iDISPATCH_SRC_READY,
  input  logic [5:0]       iDISPATCH_SRC_TAG,
  input  logic [31:0]      iDISPATCH_SRC_DATA,
  input  logic             iDISPATCH_FLAG_READY,
  input  logic [5:0]       iDISPATCH_FLAG_TAG,
  input  logic [4:0]       iDISPATCH_FLAG,
  output logic             oDISPATCH_FULL,
  input  logic             iWB_VALID,
  input  logic [5:0]       iWB_DEST_TAG,
  input  logic [31:0]      iWB_DATA,
  input  logic             iWB_FLAG_WRITE,
  input  logic [4:0]       iWB_FLAG,
  output logic             oEX_BRANCH_VALID,
  output logic [5:0]       oEX_BRANCH_COMMIT_TAG,
  output logic [4:0]       oEX_BRANCH_CMD,
  output logic [3:0]       oEX_BRANCH_CC,
  output logic [4:0]       oEX_BRANCH_FLAG,
  output logic [31:0]      oEX_BRANCH_SOURCE,
  output logic [31:0]      oEX_BRANCH_PC,
  input  logic             iEX_BRANCH_LOCK,
  output logic [PTR_W:0]   oCOUNT
);

  logic             ent_valid      [DEPTH];
  logic [5:0]       ent_tag        [DEPTH];
  logic [4:0]       ent_cmd        [DEPTH];
  logic [3:0]       ent_cc         [DEPTH];
  logic [31:0]      ent_pc         [DEPTH];
  logic             ent_src_ready  [DEPTH];
  logic [5:0]       ent_src_tag    [DEPTH];
  logic [31:0]      ent_src_data   [DEPTH];
  logic             ent_flag_ready [DEPTH];
  logic [5:0]       ent_flag_tag   [DEPTH];
  logic [4:0]       ent_flag       [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             full;
  logic             do_disp;
  logic             consume;
  logic             do_pop;
  logic             disp_src_hit;
  logic             disp_flag_hit;

  always_comb begin
    full          = (count == (PTR_W+1)'(DEPTH));
    do_disp       = iDISPATCH_VALID && !full;
    consume       = oEX_BRANCH_VALID && !iEX_BRANCH_LOCK;
    // Readiness is judged on stored state only; a wakeup arriving this
    // cycle makes the head eligible on the following cycle.
    do_pop        = (count != '0) && ent_src_ready[rd_ptr] && ent_flag_ready[rd_ptr]
                    && (!oEX_BRANCH_VALID || consume);
    disp_src_hit  = !iDISPATCH_SRC_READY && iWB_VALID
                    && (iWB_DEST_TAG == iDISPATCH_SRC_TAG);
    disp_flag_hit = !iDISPATCH_FLAG_READY && iWB_VALID && iWB_FLAG_WRITE
                    && (iWB_DEST_TAG == iDISPATCH_FLAG_TAG);
  end

  assign oDISPATCH_FULL = full;
  assign oCOUNT         = count;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iFREE_RESTART) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
      end
      oEX_BRANCH_VALID      <= 1'b0;
      oEX_BRANCH_COMMIT_TAG <= '0;
      oEX_BRANCH_CMD        <= '0;
      oEX_BRANCH_CC         <= '0;
      oEX_BRANCH_FLAG       <= '0;
      oEX_BRANCH_SOURCE     <= '0;
      oEX_BRANCH_PC         <= '0;
    end else begin
      // Writeback snoop: any number of waiting entries may wake at once.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_valid[i]) begin
          if (!ent_src_ready[i] && iWB_VALID && (iWB_DEST_TAG == ent_src_tag[i])) begin
            ent_src_ready[i] <= 1'b1;
            ent_src_data[i]  <= iWB_DATA;
          end
          if (!ent_flag_ready[i] && iWB_VALID && iWB_FLAG_WRITE
              && (iWB_DEST_TAG == ent_flag_tag[i])) begin
            ent_flag_ready[i] <= 1'b1;
            ent_flag[i]       <= iWB_FLAG;
          end
        end
      end

      if (do_pop) begin
        oEX_BRANCH_VALID      <= 1'b1;
        oEX_BRANCH_COMMIT_TAG <= ent_tag[rd_ptr];
        oEX_BRANCH_CMD        <= ent_cmd[rd_ptr];
        oEX_BRANCH_CC         <= ent_cc[rd_ptr];
        oEX_BRANCH_FLAG       <= ent_flag[rd_ptr];
        oEX_BRANCH_SOURCE     <= ent_src_data[rd_ptr];
        oEX_BRANCH_PC         <= ent_pc[rd_ptr];
        ent_valid[rd_ptr]     <= 1'b0;
        rd_ptr                <= rd_ptr + PTR_W'(1);
      end else if (consume) begin
        oEX_BRANCH_VALID <= 1'b0;
      end

      // Dispatch never targets the popped slot: a pop with wr_ptr == rd_ptr
      // implies the queue is full, which blocks dispatch.
      if (do_disp) begin
        ent_valid[wr_ptr]      <= 1'b1;
        ent_tag[wr_ptr]        <= iDISPATCH_COMMIT_TAG;
        ent_cmd[wr_ptr]        <= iDISPATCH_CMD;
        ent_cc[wr_ptr]         <= iDISPATCH_CC;
        ent_pc[wr_ptr]         <= iDISPATCH_PC;
        ent_src_ready[wr_ptr]  <= iDISPATCH_SRC_READY || disp_src_hit;
        ent_src_tag[wr_ptr]    <= iDISPATCH_SRC_TAG;
        ent_src_data[wr_ptr]   <= disp_src_hit ? iWB_DATA : iDISPATCH_SRC_DATA;
        ent_flag_ready[wr_ptr] <= iDISPATCH_FLAG_READY || disp_flag_hit;
        ent_flag_tag[wr_ptr]   <= iDISPATCH_FLAG_TAG;
        ent_flag[wr_ptr]       <= disp_flag_hit ? iWB_FLAG : iDISPATCH_FLAG;
        wr_ptr                 <= wr_ptr + PTR_W'(1);
      end

      case ({do_disp, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
module tb_branch_issue_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC, iFREE_RESTART;
  logic        iDISPATCH_VALID;
  logic [5:0]  iDISPATCH_COMMIT_TAG;
  logic [4:0]  iDISPATCH_CMD;
  logic [3:0]  iDISPATCH_CC;
  logic [31:0] iDISPATCH_PC;
  logic        iDISPATCH_SRC_READY;
  logic [5:0]  iDISPATCH_SRC_TAG;
  logic [31:0] iDISPATCH_SRC_DATA;
  logic        iDISPATCH_FLAG_READY;
  logic [5:0]  iDISPATCH_FLAG_TAG;
  logic [4:0]  iDISPATCH_FLAG;
  logic        oDISPATCH_FULL;
  logic        iWB_VALID;
  logic [5:0]  iWB_DEST_TAG;
  logic [31:0] iWB_DATA;
  logic        iWB_FLAG_WRITE;
  logic [4:0]  iWB_FLAG;
  logic        oEX_BRANCH_VALID;
  logic [5:0]  oEX_BRANCH_COMMIT_TAG;
  logic [4:0]  oEX_BRANCH_CMD;
  logic [3:0]  oEX_BRANCH_CC;
  logic [4:0]  oEX_BRANCH_FLAG;
  logic [31:0] oEX_BRANCH_SOURCE;
  logic [31:0] oEX_BRANCH_PC;
  logic        iEX_BRANCH_LOCK;
  logic [PTR_W:0] oCOUNT;

  branch_issue_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iFREE_RESTART(iFREE_RESTART),
    .iDISPATCH_VALID(iDISPATCH_VALID), .iDISPATCH_COMMIT_TAG(iDISPATCH_COMMIT_TAG),
    .iDISPATCH_CMD(iDISPATCH_CMD), .iDISPATCH_CC(iDISPATCH_CC), .iDISPATCH_PC(iDISPATCH_PC),
    .iDISPATCH_SRC_READY(iDISPATCH_SRC_READY), .iDISPATCH_SRC_TAG(iDISPATCH_SRC_TAG),
    .iDISPATCH_SRC_DATA(iDISPATCH_SRC_DATA), .iDISPATCH_FLAG_READY(iDISPATCH_FLAG_READY),
    .iDISPATCH_FLAG_TAG(iDISPATCH_FLAG_TAG), .iDISPATCH_FLAG(iDISPATCH_FLAG),
    .oDISPATCH_FULL(oDISPATCH_FULL), .iWB_VALID(iWB_VALID), .iWB_DEST_TAG(iWB_DEST_TAG),
    .iWB_DATA(iWB_DATA), .iWB_FLAG_WRITE(iWB_FLAG_WRITE), .iWB_FLAG(iWB_FLAG),
    .oEX_BRANCH_VALID(oEX_BRANCH_VALID), .oEX_BRANCH_COMMIT_TAG(oEX_BRANCH_COMMIT_TAG),
    .oEX_BRANCH_CMD(oEX_BRANCH_CMD), .oEX_BRANCH_CC(oEX_BRANCH_CC),
    .oEX_BRANCH_FLAG(oEX_BRANCH_FLAG), .oEX_BRANCH_SOURCE(oEX_BRANCH_SOURCE),
    .oEX_BRANCH_PC(oEX_BRANCH_PC), .iEX_BRANCH_LOCK(iEX_BRANCH_LOCK), .oCOUNT(oCOUNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  // Reference model: the queue is a plain list of micro-ops, oldest first.
  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  cmd;
    logic [3:0]  cc;
    logic [31:0] pc;
    logic        sr;
    logic [5:0]  st;
    logic [31:0] sd;
    logic        fr;
    logic [5:0]  ft;
    logic [4:0]  fl;
  } uop_t;

  uop_t q[$];
  logic m_ov;
  uop_t m_out;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic uop_t zero_uop();
    uop_t u;
    u.tag = '0; u.cmd = '0; u.cc = '0; u.pc = '0; u.sr = 1'b0; u.st = '0;
    u.sd = '0; u.fr = 1'b0; u.ft = '0; u.fl = '0;
    return u;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit   full, consume, pop, wb_src, wb_flg;
    uop_t n;
    if (iRESET_SYNC || iFREE_RESTART) begin
      q.delete();
      m_ov  = 1'b0;
      m_out = zero_uop();
      return;
    end
    full    = (q.size() == DEPTH);
    consume = m_ov && !iEX_BRANCH_LOCK;
    pop     = (q.size() > 0) && q[0].sr && q[0].fr && (!m_ov || consume);

    n.tag = iDISPATCH_COMMIT_TAG; n.cmd = iDISPATCH_CMD; n.cc = iDISPATCH_CC;
    n.pc  = iDISPATCH_PC; n.st = iDISPATCH_SRC_TAG; n.ft = iDISPATCH_FLAG_TAG;
    wb_src = !iDISPATCH_SRC_READY && iWB_VALID && iWB_DEST_TAG == iDISPATCH_SRC_TAG;
    wb_flg = !iDISPATCH_FLAG_READY && iWB_VALID && iWB_FLAG_WRITE
             && iWB_DEST_TAG == iDISPATCH_FLAG_TAG;
    n.sr = iDISPATCH_SRC_READY || wb_src;
    n.sd = wb_src ? iWB_DATA : iDISPATCH_SRC_DATA;
    n.fr = iDISPATCH_FLAG_READY || wb_flg;
    n.fl = wb_flg ? iWB_FLAG : iDISPATCH_FLAG;

    if (pop) begin
      m_out = q.pop_front();
      m_ov  = 1'b1;
    end else if (consume) begin
      m_ov = 1'b0;
    end
    foreach (q[i]) begin
      if (!q[i].sr && iWB_VALID && iWB_DEST_TAG == q[i].st) begin
        q[i].sr = 1'b1; q[i].sd = iWB_DATA;
      end
      if (!q[i].fr && iWB_VALID && iWB_FLAG_WRITE && iWB_DEST_TAG == q[i].ft) begin
        q[i].fr = 1'b1; q[i].fl = iWB_FLAG;
      end
    end
    if (iDISPATCH_VALID && !full) q.push_back(n);
  endtask

  task automatic compare_model();
    chk("valid", 32'(oEX_BRANCH_VALID), 32'(m_ov));
    chk("count", 32'(oCOUNT), 32'(q.size()));
    chk("full",  32'(oDISPATCH_FULL), 32'(q.size() == DEPTH));
    chk("tag",   32'(oEX_BRANCH_COMMIT_TAG), 32'(m_out.tag));
    chk("cmd",   32'(oEX_BRANCH_CMD), 32'(m_out.cmd));
    chk("cc",    32'(oEX_BRANCH_CC), 32'(m_out.cc));
    chk("flag",  32'(oEX_BRANCH_FLAG), 32'(m_out.fl));
    chk("src",   oEX_BRANCH_SOURCE, m_out.sd);
    chk("pc",    oEX_BRANCH_PC, m_out.pc);
  endtask

  // One clock: model follows the same inputs, then the DUT is compared 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge iCLOCK);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    iRESET_SYNC = 0; iFREE_RESTART = 0; iDISPATCH_VALID = 0;
    iDISPATCH_COMMIT_TAG = '0; iDISPATCH_CMD = '0; iDISPATCH_CC = '0; iDISPATCH_PC = '0;
    iDISPATCH_SRC_READY = 1; iDISPATCH_SRC_TAG = '0; iDISPATCH_SRC_DATA = '0;
    iDISPATCH_FLAG_READY = 1; iDISPATCH_FLAG_TAG = '0; iDISPATCH_FLAG = '0;
    iWB_VALID = 0; iWB_DEST_TAG = '0; iWB_DATA = '0; iWB_FLAG_WRITE = 0; iWB_FLAG = '0;
  endtask

  task automatic set_disp(input logic [5:0] tag, input logic [31:0] pc,
                          input logic sr, input logic [5:0] st, input logic [31:0] sd,
                          input logic [4:0] fl);
    iDISPATCH_VALID = 1; iDISPATCH_COMMIT_TAG = tag; iDISPATCH_CMD = 5'h0A;
    iDISPATCH_CC = 4'h3; iDISPATCH_PC = pc; iDISPATCH_SRC_READY = sr;
    iDISPATCH_SRC_TAG = st; iDISPATCH_SRC_DATA = sd;
    iDISPATCH_FLAG_READY = 1; iDISPATCH_FLAG_TAG = '0; iDISPATCH_FLAG = fl;
  endtask

  initial begin
    m_ov  = 1'b0;
    m_out = zero_uop();
    idle_inputs();
    iEX_BRANCH_LOCK = 0;
    #2;

    // 1. Reset with dispatch active.
    iRESET_SYNC = 1;
    set_disp(6'h01, 32'h10, 1, '0, 32'h1, 5'h1);
    tick(); tick();
    chk("rst_valid", 32'(oEX_BRANCH_VALID), 0);
    chk("rst_count", 32'(oCOUNT), 0);
    chk("rst_full",  32'(oDISPATCH_FULL), 0);
    chk("rst_pc",    oEX_BRANCH_PC, 0);
    idle_inputs();

    // 2. Ready branch: valid two cycles after dispatch.
    set_disp(6'h05, 32'h1000, 1, '0, 32'h2000, 5'h03);
    tick(); idle_inputs();
    chk("rdy_c1_valid", 32'(oEX_BRANCH_VALID), 0);
    tick();
    chk("rdy_valid", 32'(oEX_BRANCH_VALID), 1);
    chk("rdy_tag",   32'(oEX_BRANCH_COMMIT_TAG), 32'h05);
    chk("rdy_pc",    oEX_BRANCH_PC, 32'h1000);
    chk("rdy_src",   oEX_BRANCH_SOURCE, 32'h2000);
    chk("rdy_flag",  32'(oEX_BRANCH_FLAG), 32'h03);
    tick();
    chk("rdy_c3_valid", 32'(oEX_BRANCH_VALID), 0);
    chk("rdy_c3_count", 32'(oCOUNT), 0);

    // 3a. Wakeup from writeback in cycle 3.
    set_disp(6'h07, 32'h2000, 0, 6'h11, 32'h0, 5'h01);
    tick(); idle_inputs();          // cycle 0
    tick(); tick();                 // cycles 1, 2
    iWB_VALID = 1; iWB_DEST_TAG = 6'h11; iWB_DATA = 32'hDEADBEEF;
    tick(); idle_inputs();          // cycle 3
    chk("wk_c4_valid", 32'(oEX_BRANCH_VALID), 0);
    tick();                         // cycle 4
    chk("wk_c5_valid", 32'(oEX_BRANCH_VALID), 1);
    chk("wk_c5_src",   oEX_BRANCH_SOURCE, 32'hDEADBEEF);
    tick();

    // 3b. Writeback in the dispatch cycle itself.
    set_disp(6'h08, 32'h2004, 0, 6'h11, 32'h0, 5'h01);
    iWB_VALID = 1; iWB_DEST_TAG = 6'h11; iWB_DATA = 32'hCAFEF00D;
    tick(); idle_inputs();
    tick();
    chk("byp_valid", 32'(oEX_BRANCH_VALID), 1);
    chk("byp_src",   oEX_BRANCH_SOURCE, 32'hCAFEF00D);
    tick();

    // 4. Fill with LOCK held, sixth dispatch dropped, then drain in order.
    iEX_BRANCH_LOCK = 1;
    for (int i = 1; i <= 6; i++) begin
      set_disp(6'(i), 32'h3000 + 32'(i), 1, '0, 32'(i), 5'h02);
      tick();
    end
    idle_inputs();
    chk("full_flag",  32'(oDISPATCH_FULL), 1);
    chk("full_count", 32'(oCOUNT), 4);
    chk("full_head",  32'(oEX_BRANCH_COMMIT_TAG), 1);
    iEX_BRANCH_LOCK = 0;
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("drain_valid", 32'(oEX_BRANCH_VALID), 1);
      chk("drain_tag",   32'(oEX_BRANCH_COMMIT_TAG), 32'(i));
    end
    tick();
    chk("drain_end", 32'(oEX_BRANCH_VALID), 0);

    // 5. Stall: payload held while LOCK, transfer on first release.
    set_disp(6'h2A, 32'h4000, 1, '0, 32'h44, 5'h04);
    tick();
    set_disp(6'h2B, 32'h4004, 1, '0, 32'h45, 5'h05);
    tick(); idle_inputs();
    iEX_BRANCH_LOCK = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_tag", 32'(oEX_BRANCH_COMMIT_TAG), 32'h2A);
    end
    iEX_BRANCH_LOCK = 0;
    tick();
    chk("stall_next", 32'(oEX_BRANCH_COMMIT_TAG), 32'h2B);
    tick();

    // 6. Flush with dispatch and writeback in the same cycle.
    iEX_BRANCH_LOCK = 1;
    for (int i = 0; i < 4; i++) begin
      set_disp(6'(16 + i), 32'h5000, 1, '0, 32'h0, 5'h0);
      tick();
    end
    iFREE_RESTART = 1;
    set_disp(6'h3F, 32'h6000, 1, '0, 32'h0, 5'h0);
    iWB_VALID = 1;
    tick(); idle_inputs();
    chk("flush_count", 32'(oCOUNT), 0);
    chk("flush_valid", 32'(oEX_BRANCH_VALID), 0);
    iEX_BRANCH_LOCK = 0;
    tick();
    chk("flush_nostore", 32'(oEX_BRANCH_VALID), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      iRESET_SYNC          = ($urandom_range(0, 199) == 0);
      iFREE_RESTART        = ($urandom_range(0, 99) == 0);
      iEX_BRANCH_LOCK      = ($urandom_range(0, 2) == 0);
      iDISPATCH_VALID      = $urandom_range(0, 1) == 1;
      iDISPATCH_COMMIT_TAG = 6'($urandom);
      iDISPATCH_CMD        = 5'($urandom);
      iDISPATCH_CC         = 4'($urandom);
      iDISPATCH_PC         = $urandom;
      iDISPATCH_SRC_READY  = $urandom_range(0, 1) == 1;
      iDISPATCH_SRC_TAG    = 6'($urandom_range(0, 7));
      iDISPATCH_SRC_DATA   = $urandom;
      iDISPATCH_FLAG_READY = $urandom_range(0, 1) == 1;
      iDISPATCH_FLAG_TAG   = 6'($urandom_range(0, 7));
      iDISPATCH_FLAG       = 5'($urandom);
      iWB_VALID            = $urandom_range(0, 1) == 1;
      iWB_DEST_TAG         = 6'($urandom_range(0, 7));
      iWB_DATA             = $urandom;
      iWB_FLAG_WRITE       = $urandom_range(0, 1) == 1;
      iWB_FLAG             = 5'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_issue_queue.md
Name: branch_issue_queue

Overview:
In-order issue queue that holds dispatched branch micro-ops until their source operand and condition flags are available. It then drives them, one per handshake, into the branch execute port. It is the sending end of the execute-branch interface (VALID/payload out, LOCK back). It sits between rename/dispatch and the branch execute port, and snoops the writeback bus for operand wakeup.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2.
PTR_W, 2, log2(DEPTH); occupancy counter is PTR_W+1 bits.

Ports:
iCLOCK  in  1  clock, all state on rising edge
iRESET_SYNC  in  1  synchronous, active-high reset
iFREE_RESTART  in  1  pipeline flush; synchronous, same effect as reset
iDISPATCH_VALID  in  1  dispatch request this cycle
iDISPATCH_COMMIT_TAG  in  6  commit tag of branch
iDISPATCH_CMD  in  5  branch command
iDISPATCH_CC  in  4  condition code
iDISPATCH_PC  in  32  branch PC
iDISPATCH_SRC_READY  in  1  1 = iDISPATCH_SRC_DATA valid
iDISPATCH_SRC_TAG  in  6  producer tag when not ready
iDISPATCH_SRC_DATA  in  32  source value when ready
iDISPATCH_FLAG_READY  in  1  1 = iDISPATCH_FLAG valid
iDISPATCH_FLAG_TAG  in  6  flag producer tag when not ready
iDISPATCH_FLAG  in  5  flags when ready
oDISPATCH_FULL  out  1  queue full; dispatch is dropped
iWB_VALID  in  1  writeback bus valid
iWB_DEST_TAG  in  6  writeback producer tag
iWB_DATA  in  32  writeback data
iWB_FLAG_WRITE  in  1  this writeback also produces flags
iWB_FLAG  in  5  written flags
oEX_BRANCH_VALID  out  1  issue valid to execute port
oEX_BRANCH_COMMIT_TAG  out  6
oEX_BRANCH_CMD  out  5
oEX_BRANCH_CC  out  4
oEX_BRANCH_FLAG  out  5
oEX_BRANCH_SOURCE  out  32
oEX_BRANCH_PC  out  32
iEX_BRANCH_LOCK  in  1  execute port busy; issue is not accepted
oCOUNT  out  PTR_W+1  entries in queue (excludes output stage)

Behaviour:
- Reset and flush: iRESET_SYNC or iFREE_RESTART clears the following on the next edge:
  - all entry valid bits, pointers and count go to 0;
  - the output stage goes to 0; oEX_BRANCH_VALID and every oEX_BRANCH_* payload = 0;
  - oDISPATCH_FULL = 0 and oCOUNT = 0.
  Reset/flush has priority over dispatch, wakeup and issue in the same cycle.
- Storage: circular FIFO with wr_ptr, rd_ptr and count.
  - Each entry holds tag, cmd, cc, pc, src_ready, src_tag, src_data, flag_ready, flag_tag and flag.
  - Pointers wrap modulo DEPTH.
- Full: oDISPATCH_FULL = (count == DEPTH), combinational from count only.
  - Dispatch while full is ignored, even if a pop occurs the same cycle.
- Dispatch: when iDISPATCH_VALID && !full, the entry is written at wr_ptr on the edge.
- Dispatch-cycle wakeup bypass: if the operand is not ready and iWB_VALID && iWB_DEST_TAG == iDISPATCH_SRC_TAG in the same cycle, the entry is stored with src_ready = 1 and src_data = iWB_DATA.
  - Flags likewise, additionally requiring iWB_FLAG_WRITE.
- Wakeup of stored entries: every cycle, each valid entry with !src_ready and a matching iWB_DEST_TAG captures iWB_DATA and sets src_ready.
  - For flags: !flag_ready, a matching tag and iWB_FLAG_WRITE captures iWB_FLAG and sets flag_ready.
  - Multiple entries may wake on one writeback.
- Output stage: register out_valid plus payload, which drives oEX_BRANCH_* directly.
  - consume = out_valid && !iEX_BRANCH_LOCK.
  - The payload holds stable while out_valid && iEX_BRANCH_LOCK.
- Transfer: head entry moves to the output stage when:
  - count != 0, and
  - head src_ready && flag_ready, as stored, with no same-cycle wakeup bypass into the output stage, and
  - (!out_valid || consume).
  On transfer: pop head, rd_ptr++, out_valid <= 1. Otherwise, if consume, out_valid <= 0.
- Ordering: strictly in order; a non-ready head blocks younger ready entries.
- Count update: dispatch and pop in the same cycle leave count unchanged.
- Latency: with ready operands and no LOCK, dispatch in cycle 0 gives oEX_BRANCH_VALID in cycle 2. Back-to-back issues are possible every cycle.
- LOCK can stay high until iFREE_RESTART; the queue simply stalls.

Test Plan:
1. Reset: assert iRESET_SYNC 2 cycles with dispatch active -> oEX_BRANCH_VALID = 0, oCOUNT = 0, oDISPATCH_FULL = 0, payload = 0.
2. Ready branch, LOCK = 0: dispatch tag 0x05, PC 0x1000, SRC 0x2000, FLAG 0x03 in cycle 0 -> cycle 2 oEX_BRANCH_VALID = 1 with those values; cycle 3 VALID = 0 and oCOUNT = 0.
3. Wakeup: dispatch with SRC_TAG 0x11 not ready; WB tag 0x11 data 0xDEADBEEF in cycle 3 -> VALID in cycle 5 with SOURCE = 0xDEADBEEF. Repeat with WB in the dispatch cycle -> VALID in cycle 2.
4. Full and wrap: 6 ready dispatches with LOCK = 1 -> oDISPATCH_FULL after 5 accepted (4 queued + 1 output); 6th dropped. Release LOCK -> tags issue in order over 5 consecutive cycles; pointers wrap.
5. Stall: LOCK held 3 cycles while VALID -> payload constant; transfer happens exactly on the first LOCK = 0 cycle.
6. Flush: 3 entries queued plus output valid, pulse iFREE_RESTART together with dispatch and WB -> next cycle all empty, VALID = 0, and the dispatched entry is not stored.
